// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the upstream-FIFO round-robin drain scheduler and its FIFOs.
package fifo_rr_arbiter_pkg;

   localparam int DEF_N_PORTS   = 4;
   localparam int DEF_DATA_SIZE = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   // Bits needed to index n items; never less than one so a bus always exists.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Masked priority encoder: first eligible port strictly after ptr, wrapping at N_PORTS-1.
module rr_pick
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int N_PORTS = DEF_N_PORTS,
   parameter int W       = idx_width(DEF_N_PORTS)
) (
   input  logic [N_PORTS-1:0] eligible,
   input  logic [W-1:0]       ptr,
   output logic               valid,
   output logic [N_PORTS-1:0] onehot,
   output logic [W-1:0]       index
);

   always_comb begin
      int         cand;
      logic [W-1:0] cand_idx;
      valid    = 1'b0;
      onehot   = '0;
      index    = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_PORTS) cand = cand - N_PORTS;
         cand_idx = W'(cand);
         if (!valid && eligible[cand_idx]) begin
            valid = 1'b1;
            index = cand_idx;
         end
      end
      if (valid) onehot[index] = 1'b1;
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains N_PORTS upstream FIFOs round-robin into one downstream FIFO, honouring pause.
// Optional feature: define ARB_BURST_EN to let a port keep the grant for up to BURST_MAX words.
module fifo_rr_arbiter
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int N_PORTS   = DEF_N_PORTS,
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int BURST_MAX = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_PORTS-1:0]             empty_in,
   input  logic [N_PORTS*DATA_SIZE-1:0]   data_in,
   input  logic                           pause_in,
   output logic [N_PORTS-1:0]             pop,
   output logic                           push,
   output logic [DATA_SIZE-1:0]           data_out,
   output logic [idx_width(N_PORTS)-1:0]  grant_id,
   output logic                           busy
);

   localparam int W  = idx_width(N_PORTS);
   localparam int BW = idx_width(BURST_MAX + 1);

`ifdef ARB_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   arb_state_t           state;
   logic [W-1:0]         last_ptr;
   logic [BW-1:0]        burst_cnt;
   logic [N_PORTS-1:0]   eligible;
   logic                 can_pop;
   logic                 hold;
   logic                 pop_any;
   logic                 pick_valid;
   logic [N_PORTS-1:0]   pick_onehot;
   logic [W-1:0]         pick_index;
   logic [W-1:0]         pop_index;
   logic [DATA_SIZE-1:0] words [N_PORTS];

   assign eligible = ~empty_in;

   rr_pick #(
      .N_PORTS (N_PORTS),
      .W       (W)
   ) u_pick (
      .eligible (eligible),
      .ptr      (last_ptr),
      .valid    (pick_valid),
      .onehot   (pick_onehot),
      .index    (pick_index)
   );

   assign can_pop = !pause_in && pick_valid;

   // burst_cnt is nonzero only right after a pop, so grant_id names the port being held.
   assign hold = BURST_EN && (burst_cnt != '0) && eligible[grant_id]
                 && (burst_cnt < BW'(BURST_MAX));

   always_comb begin
      pop       = '0;
      pop_index = pick_index;
      if (can_pop) begin
         if (hold) begin
            pop[grant_id] = 1'b1;
            pop_index     = grant_id;
         end else begin
            pop = pick_onehot;
         end
      end
   end

   assign pop_any = |pop;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         push      <= 1'b0;
         grant_id  <= '0;
         last_ptr  <= W'(N_PORTS - 1);
         burst_cnt <= '0;
      end else begin
         push <= pop_any;
         if (pop_any) begin
            grant_id  <= pop_index;
            last_ptr  <= pop_index;
            burst_cnt <= hold ? burst_cnt + 1'b1 : BW'(1);
         end else begin
            burst_cnt <= '0;
         end
         if (pop_any) begin
            state <= RUN;
            busy  <= 1'b1;
         end else if (state == RUN) begin
            state <= DRAIN;
            busy  <= 1'b1;
         end else begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < N_PORTS; i++) begin : g_words
      assign words[i] = data_in[i*DATA_SIZE +: DATA_SIZE];
   end

   assign data_out = push ? words[grant_id] : '0;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with a small upstream FIFO model; define ARB_BURST_EN for the burst case.
module tb_fifo_rr_arbiter;
   import fifo_rr_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  empty_in;
   logic [39:0] data_in;
   logic        pause_in;
   logic [3:0]  pop;
   logic        push;
   logic [9:0]  data_out;
   logic [1:0]  grant_id;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [9:0] mem [4][8];
   int         wr [4];
   int         rd [4];
   logic [3:0] lastPop;

   fifo_rr_arbiter #(.N_PORTS(4), .DATA_SIZE(10), .BURST_MAX(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .empty_in (empty_in),
      .data_in  (data_in),
      .pause_in (pause_in),
      .pop      (pop),
      .push     (push),
      .data_out (data_out),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic refreshEmpty();
      for (int i = 0; i < 4; i++) empty_in[i] = (rd[i] == wr[i]);
   endtask

   task automatic loadWord(input int p, input logic [9:0] w);
      mem[p][wr[p]] = w;
      wr[p]++;
      refreshEmpty();
   endtask

   // One clock: capture mid-cycle pop, let the edge happen, then advance the FIFO model.
   task automatic applyStimulus();
      #1 lastPop = pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (lastPop[i] && rd[i] < wr[i]) begin
            data_in[i*10 +: 10] = mem[i][rd[i]];
            rd[i]++;
         end
      end
      refreshEmpty();
      @(negedge clk);
   endtask

   initial begin
      reset    = 1'b0;
      pause_in = 1'b0;
      empty_in = 4'hF;
      data_in  = '0;
      lastPop  = '0;
      for (int i = 0; i < 4; i++) begin
         wr[i] = 0;
         rd[i] = 0;
      end
      @(negedge clk);
      applyStimulus();
      applyStimulus();

      checkOutput("reset_pop", pop, 0);
      checkOutput("reset_push", push, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_gid", grant_id, 0);
      checkOutput("reset_data", data_out, 0);
      checkOutput("reset_state", dut.state, IDLE);

      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         applyStimulus();
         checkOutput("idle_pop", pop, 0);
         checkOutput("idle_state", dut.state, IDLE);
      end
      checkOutput("idle_busy", busy, 0);

      $display("[TB] round robin over four loaded ports");
      for (int n = 0; n < 2; n++)
         for (int p = 0; p < 4; p++) loadWord(p, 10'(10'h100 + p*16 + n));
      #1;
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("rr_pop_%0d", k), pop, 32'(1 << (k % 4)));
         if (k > 0) begin
            checkOutput("rr_push", push, 1);
            checkOutput("rr_gid", grant_id, (k - 1) % 4);
            checkOutput("rr_data", data_out, 10'h100 + ((k - 1) % 4) * 16 + (k - 1) / 4);
         end
         applyStimulus();
      end
      checkOutput("rr_tail_pop", pop, 0);
      checkOutput("rr_tail_push", push, 1);
      checkOutput("rr_tail_gid", grant_id, 3);
      checkOutput("rr_tail_data", data_out, 10'h131);
      applyStimulus();
      checkOutput("rr_drain_state", dut.state, DRAIN);
      checkOutput("rr_drain_push", push, 0);
      checkOutput("rr_drain_busy", busy, 1);
      applyStimulus();
      checkOutput("rr_idle_state", dut.state, IDLE);
      checkOutput("rr_idle_busy", busy, 0);

      $display("[TB] single port with three words");
      loadWord(2, 10'h0A1);
      loadWord(2, 10'h0A2);
      loadWord(2, 10'h0A3);
      #1;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("p2_pop_%0d", k), pop, (k < 3) ? 4 : 0);
         if (k > 0) begin
            checkOutput("p2_gid", grant_id, 2);
            checkOutput("p2_data", data_out, 10'h0A0 + k);
         end
         applyStimulus();
      end
      checkOutput("p2_after_push", push, 0);
      checkOutput("p2_after_pop", pop, 0);
      applyStimulus();

      $display("[TB] pause after a pop");
      loadWord(0, 10'h200);
      loadWord(0, 10'h201);
      loadWord(1, 10'h210);
      loadWord(3, 10'h230);
      loadWord(3, 10'h231);
      #1;
      checkOutput("pause_first_pop", pop, 4'b1000);
      applyStimulus();
      pause_in = 1'b1;
      #1;
      checkOutput("pause_block_pop", pop, 0);
      checkOutput("pause_owed_push", push, 1);
      checkOutput("pause_owed_gid", grant_id, 3);
      checkOutput("pause_owed_data", data_out, 10'h230);
      applyStimulus();
      for (int c = 0; c < 3; c++) begin
         checkOutput("paused_pop", pop, 0);
         checkOutput("paused_push", push, 0);
         applyStimulus();
      end
      checkOutput("paused_state", dut.state, IDLE);
      pause_in = 1'b0;
      #1;
      checkOutput("resume_pop0", pop, 4'b0001);
      applyStimulus();
      checkOutput("resume_pop1", pop, 4'b0010);
      checkOutput("resume_data", data_out, 10'h200);
      applyStimulus();
      checkOutput("resume_pop2", pop, 4'b1000);
      checkOutput("resume_data2", data_out, 10'h210);
      applyStimulus();
      checkOutput("resume_pop3", pop, 4'b0001);
      applyStimulus();
      checkOutput("resume_empty_pop", pop, 0);
      checkOutput("resume_last_data", data_out, 10'h201);
      applyStimulus();
      applyStimulus();

      $display("[TB] reset in the cycle after a pop");
      loadWord(1, 10'h310);
      #1;
      checkOutput("mid_pop", pop, 4'b0010);
      applyStimulus();
      reset = 1'b0;
      applyStimulus();
      checkOutput("mid_reset_push", push, 0);
      checkOutput("mid_reset_state", dut.state, IDLE);
      checkOutput("mid_reset_busy", busy, 0);
      checkOutput("mid_reset_ptr", dut.last_ptr, 3);
      reset = 1'b1;
      loadWord(0, 10'h300);
      loadWord(2, 10'h320);
      #1;
      checkOutput("post_reset_pop", pop, 4'b0001);
      applyStimulus();
      checkOutput("post_reset_data", data_out, 10'h300);
      checkOutput("post_reset_pop2", pop, 4'b0100);
      applyStimulus();
      checkOutput("post_reset_data2", data_out, 10'h320);
      applyStimulus();
      applyStimulus();

`ifdef ARB_BURST_EN
      $display("[TB] burst hold on port 0");
      for (int n = 0; n < 6; n++) loadWord(0, 10'(10'h400 + n));
      loadWord(1, 10'h410);
      #1;
      begin
         int ord [7] = '{0, 0, 0, 0, 1, 0, 0};
         for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("burst_pop_%0d", k), pop, 32'(1 << ord[k]));
            applyStimulus();
         end
      end
      checkOutput("burst_end_pop", pop, 0);
      applyStimulus();
      applyStimulus();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
